// File: rtl/cacheline_bmem_arbiter_if.sv
// Signal bundle between the instruction cache, the data cache, the arbiter and the burst port.
// master is the arbiter's view of the bundle; slave is the view of the caches and memory.
interface cacheline_bmem_arbiter_if #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
);
  logic [31:0]           icache_address;
  logic                  icache_read;
  logic [LINE_WIDTH-1:0] icache_rdata;
  logic                  icache_resp;

  logic [31:0]           dcache_address;
  logic                  dcache_read;
  logic                  dcache_write;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  dcache_resp;

  logic [31:0]           bmem_address;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_resp;

  modport master (
    input  icache_address, icache_read,
    input  dcache_address, dcache_read, dcache_write, dcache_wdata,
    input  bmem_rdata, bmem_resp,
    output icache_rdata, icache_resp,
    output dcache_rdata, dcache_resp,
    output bmem_address, bmem_read, bmem_write, bmem_wdata
  );

  modport slave (
    output icache_address, icache_read,
    output dcache_address, dcache_read, dcache_write, dcache_wdata,
    output bmem_rdata, bmem_resp,
    input  icache_rdata, icache_resp,
    input  dcache_rdata, dcache_resp,
    input  bmem_address, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/cacheline_bmem_arbiter.sv
// Round-robin arbiter between icache and dcache line traffic onto one burst-memory port;
// each cacheline moves as LINE_WIDTH/BEAT_WIDTH beats and completes with a one-cycle resp.
module cacheline_bmem_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input logic                      clk,
  input logic                      rst,
  cacheline_bmem_arbiter_if.master bus
);

  localparam int unsigned NumBeats   = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntWidth   = $clog2(NumBeats);
  localparam int unsigned OffsetBits = $clog2(LINE_WIDTH / 8);
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NumBeats - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdBurst,
    StWrBurst,
    StWrWait,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   beat_q, beat_d;
  logic                  last_grant_q, last_grant_d;  // 1: dcache was granted last
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;

  logic icache_req, dcache_req, any_req, grant_dcache;

  assign icache_req = bus.icache_read;
  assign dcache_req = bus.dcache_read | bus.dcache_write;
  assign any_req    = icache_req | dcache_req;
  // On a tie the cache that lost last time wins.
  assign grant_dcache = dcache_req & (~icache_req | ~last_grant_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = (grant_dcache && bus.dcache_write) ? StWrBurst : StRdBurst;
        end
      end
      StRdBurst: begin
        if (bus.bmem_resp && (beat_q == LastBeat)) state_d = StResp;
      end
      StWrBurst: begin
        if (beat_q == LastBeat) state_d = StWrWait;
      end
      StWrWait: begin
        if (bus.bmem_resp) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_wdata  = '0;
    bus.icache_resp = 1'b0;
    bus.dcache_resp = 1'b0;
    unique case (state_q)
      StRdBurst: bus.bmem_read = 1'b1;
      StWrBurst: begin
        bus.bmem_write = 1'b1;
        bus.bmem_wdata = bus.dcache_wdata[beat_q*BEAT_WIDTH +: BEAT_WIDTH];
      end
      StResp: begin
        bus.icache_resp = ~last_grant_q;
        bus.dcache_resp = last_grant_q;
      end
      default: ;
    endcase
  end

  assign bus.bmem_address = addr_q;
  assign bus.icache_rdata = line_q;
  assign bus.dcache_rdata = line_q;

  // Beat counter wraps to zero after the last beat, so it is clean again in RESP.
  always_comb begin
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    line_d       = line_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          last_grant_d = grant_dcache;
          addr_d       = grant_dcache ? bus.dcache_address : bus.icache_address;
          addr_d[OffsetBits-1:0] = '0;
        end
      end
      StRdBurst: begin
        if (bus.bmem_resp) begin
          line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = bus.bmem_rdata;
          beat_d = beat_q + 1'b1;
        end
      end
      StWrBurst: beat_d = beat_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_q       <= '0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      line_q       <= '0;
    end else begin
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
    end
  end

endmodule

// File: tb/tb_cacheline_bmem_arbiter.sv
// Bench for cacheline_bmem_arbiter: a burst-memory responder, a table of arbitration vectors,
// hand-written corner sequences and randomized trials checked against a round-robin model.
module tb_cacheline_bmem_arbiter;
  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  cacheline_bmem_arbiter_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) bus ();

  cacheline_bmem_arbiter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Memory responder knobs.
  bit          fixed_mode  = 1'b0;
  logic [63:0] fixed_beats [4];
  int          gaps [4]    = '{0, 0, 0, 0};
  int          wr_gap      = 0;
  bit          junk_en     = 1'b0;
  logic [31:0] salt        = 32'h0;
  int          wr_done_cyc = -1;

  function automatic logic [63:0] mem_word(logic [31:0] a, int idx, logic [31:0] s);
    return {a + 32'(idx) * 32'h0101_0101, a ^ s ^ 32'(idx << 8)};
  endfunction

  function automatic logic [255:0] exp_line(logic [31:0] a, logic [31:0] s);
    logic [255:0] l;
    logic [31:0]  al;
    al = a & 32'hFFFF_FFE0;
    for (int i = 0; i < 4; i++) l[i*64 +: 64] = mem_word(al, i, s);
    return l;
  endfunction

  // Burst memory: serves read beats with programmable gaps, acknowledges writes after wr_gap.
  int rd_idx, gap_left, wr_seen, wgap_left;
  bit rd_active;
  always @(posedge clk) begin
    #1;
    bus.bmem_resp  = 1'b0;
    bus.bmem_rdata = {$urandom, $urandom};
    if (!rst) begin
      rd_active = 1'b0;
      wr_seen   = 0;
    end else if (bus.bmem_read) begin
      if (!rd_active) begin
        rd_active = 1'b1;
        rd_idx    = 0;
        gap_left  = gaps[0];
      end
      if (gap_left > 0) begin
        gap_left--;
      end else if (rd_idx < 4) begin
        bus.bmem_resp  = 1'b1;
        bus.bmem_rdata = fixed_mode ? fixed_beats[rd_idx] : mem_word(bus.bmem_address, rd_idx, salt);
        rd_idx++;
        if (rd_idx < 4) gap_left = gaps[rd_idx];
      end
    end else if (bus.bmem_write) begin
      rd_active = 1'b0;
      if (wr_seen == 0) wgap_left = wr_gap;
      wr_seen++;
    end else if (wr_seen > 0) begin
      if (wgap_left > 0) begin
        wgap_left--;
      end else begin
        bus.bmem_resp = 1'b1;
        wr_done_cyc   = cyc;
        wr_seen       = 0;
      end
    end else begin
      rd_active = 1'b0;
      if (junk_en) bus.bmem_resp = 1'($urandom_range(0, 1));
    end
  end

  // Monitor state, updated by step().
  int           i_resps, d_resps, rd_starts, i_resp_cyc, d_resp_cyc, rd_start_cyc, wr_start_cyc;
  logic [255:0] i_line, d_line;
  logic [63:0]  wr_beats [$];
  logic [31:0]  burst_addr [$];
  bit           served [$];
  bit           prev_rd, prev_wr;

  task automatic clear_mon();
    i_resps = 0; d_resps = 0; rd_starts = 0;
    i_resp_cyc = -1; d_resp_cyc = -1; rd_start_cyc = -1; wr_start_cyc = -1;
    wr_beats.delete(); burst_addr.delete(); served.delete();
  endtask

  // One clock: sample at the falling edge, then release requests the cycle after their resp.
  task automatic step();
    bit drop_i, drop_d;
    @(negedge clk);
    drop_i = 1'b0;
    drop_d = 1'b0;
    if (bus.icache_resp) begin
      i_resps++; i_resp_cyc = cyc; i_line = bus.icache_rdata; served.push_back(1'b0);
      drop_i = 1'b1;
    end
    if (bus.dcache_resp) begin
      d_resps++; d_resp_cyc = cyc; d_line = bus.dcache_rdata; served.push_back(1'b1);
      drop_d = 1'b1;
    end
    if (bus.bmem_read && !prev_rd) begin
      rd_starts++; rd_start_cyc = cyc; burst_addr.push_back(bus.bmem_address);
    end
    if (bus.bmem_write) begin
      if (!prev_wr) begin
        wr_start_cyc = cyc; burst_addr.push_back(bus.bmem_address);
      end
      wr_beats.push_back(bus.bmem_wdata);
    end
    prev_rd = bus.bmem_read;
    prev_wr = bus.bmem_write;
    @(posedge clk);
    #1;
    if (drop_i) bus.icache_read = 1'b0;
    if (drop_d) begin
      bus.dcache_read  = 1'b0;
      bus.dcache_write = 1'b0;
    end
  endtask

  task automatic wait_resps(string name, int n, int bound);
    int k = 0;
    while ((i_resps + d_resps) < n && k < bound) begin
      step();
      k++;
    end
    chk(name, 256'(i_resps + d_resps), 256'(n));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic drop_all();
    bus.icache_read  = 1'b0;
    bus.dcache_read  = 1'b0;
    bus.dcache_write = 1'b0;
  endtask

  typedef struct {
    bit          rst_first;
    bit          i_rd, d_rd, d_wr;
    logic [31:0] ia, da;
    bit          exp_d;
    bit          exp_wr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        vecs [8];
  logic [63:0] exp_wb [4];
  int          c0;

  initial begin
    drop_all();
    bus.icache_address = '0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    clear_mon();
    fixed_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    @(posedge clk);
    #1;

    // Reset values.
    do_reset();
    chk("rst_bmem_read", 256'(bus.bmem_read), 256'(0));
    chk("rst_bmem_write", 256'(bus.bmem_write), 256'(0));
    chk("rst_icache_resp", 256'(bus.icache_resp), 256'(0));
    chk("rst_dcache_resp", 256'(bus.dcache_resp), 256'(0));
    chk("rst_bmem_address", 256'(bus.bmem_address), 256'(0));
    chk("rst_bmem_wdata", 256'(bus.bmem_wdata), 256'(0));
    chk("rst_icache_rdata", bus.icache_rdata, 256'(0));
    chk("rst_dcache_rdata", bus.dcache_rdata, 256'(0));

    // icache read, back-to-back beats.
    clear_mon();
    fixed_mode = 1'b1;
    c0 = cyc;
    bus.icache_address = 32'h0000_1234;
    bus.icache_read    = 1'b1;
    wait_resps("ird_done", 1, 30);
    chk("ird_addr", 256'(burst_addr[0]), 256'(32'h0000_1220));
    chk("ird_read_start", 256'(rd_start_cyc - c0), 256'(1));
    chk("ird_resp_cycle", 256'(i_resp_cyc - c0), 256'(5));
    chk("ird_line", i_line, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    repeat (6) step();
    chk("ird_one_resp", 256'(i_resps), 256'(1));
    chk("ird_no_dresp", 256'(d_resps), 256'(0));
    chk("ird_one_burst", 256'(rd_starts), 256'(1));

    // dcache writeback.
    clear_mon();
    wr_gap = 2;
    exp_wb = '{64'h76543210_89abcdef, 64'h11223344_55667788,
               64'hdeadbeef_cafef00d, 64'h01234567_89abcdef};
    c0 = cyc;
    bus.dcache_wdata   = 256'h01234567_89abcdef_deadbeef_cafef00d_11223344_55667788_76543210_89abcdef;
    bus.dcache_address = 32'hdead_beef;
    bus.dcache_write   = 1'b1;
    wait_resps("dwr_done", 1, 30);
    chk("dwr_start", 256'(wr_start_cyc - c0), 256'(1));
    chk("dwr_beat_count", 256'(wr_beats.size()), 256'(4));
    for (int i = 0; i < 4 && i < wr_beats.size(); i++) chk($sformatf("dwr_beat%0d", i),
                                                           256'(wr_beats[i]), 256'(exp_wb[i]));
    chk("dwr_addr", 256'(burst_addr[0]), 256'(32'hdead_bee0));
    chk("dwr_resp_after_ack", 256'(d_resp_cyc - wr_done_cyc), 256'(1));
    chk("dwr_no_iresp", 256'(i_resps), 256'(0));
    wr_gap = 0;

    // Memory wait states between beats 1 and 2.
    clear_mon();
    gaps = '{0, 0, 3, 0};
    c0 = cyc;
    bus.dcache_address = 32'h0000_0040;
    bus.dcache_read    = 1'b1;
    wait_resps("wait_done", 1, 30);
    chk("wait_resp_cycle", 256'(d_resp_cyc - c0), 256'(8));
    chk("wait_line", d_line, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    gaps = '{0, 0, 0, 0};

    // Reset during a read burst, after three beats have landed.
    clear_mon();
    bus.icache_address = 32'h0000_4321;
    bus.icache_read    = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    step();
    chk("rstmid_bmem_read", 256'(bus.bmem_read), 256'(0));
    chk("rstmid_line_cleared", bus.icache_rdata, 256'(0));
    bus.icache_read = 1'b0;
    step();
    rst = 1'b1;
    repeat (6) step();
    chk("rstmid_no_resp", 256'(i_resps + d_resps), 256'(0));
    clear_mon();
    c0 = cyc;
    bus.icache_address = 32'h0000_8888;
    bus.icache_read    = 1'b1;
    wait_resps("rstmid_fresh_done", 1, 30);
    chk("rstmid_fresh_cycle", 256'(i_resp_cyc - c0), 256'(5));
    chk("rstmid_fresh_addr", 256'(burst_addr[0]), 256'(32'h0000_8880));
    chk("rstmid_fresh_line", i_line, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Request held through its resp cycle yields exactly one burst.
    clear_mon();
    bus.icache_address = 32'h0000_0100;
    bus.icache_read    = 1'b1;
    wait_resps("held_done", 1, 30);
    repeat (8) step();
    chk("held_one_burst", 256'(rd_starts), 256'(1));
    chk("held_one_resp", 256'(i_resps), 256'(1));

    // Simultaneous requests after reset: dcache first; later a pair after a dcache grant.
    fixed_mode = 1'b0;
    salt = 32'h1357_9bdf;
    do_reset();
    clear_mon();
    bus.icache_address = 32'h0000_0a00;
    bus.dcache_address = 32'h0000_0b00;
    bus.icache_read    = 1'b1;
    bus.dcache_read    = 1'b1;
    wait_resps("tie1_done", 2, 60);
    chk("tie1_first_dcache", 256'(served[0]), 256'(1));
    chk("tie1_second_icache", 256'(served[1]), 256'(0));
    chk("tie1_iline", i_line, exp_line(32'h0000_0a00, salt));
    chk("tie1_dline", d_line, exp_line(32'h0000_0b00, salt));
    clear_mon();
    bus.dcache_read = 1'b1;
    wait_resps("tie_dsolo_done", 1, 30);
    clear_mon();
    bus.icache_read = 1'b1;
    bus.dcache_read = 1'b1;
    wait_resps("tie2_done", 2, 60);
    chk("tie2_first_icache", 256'(served[0]), 256'(0));
    chk("tie2_second_dcache", 256'(served[1]), 256'(1));

    // Arbitration vectors: grant winner, burst type and aligned address.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_2000};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0001_0040, 32'h0003_0000, 1'b0, 1'b0, 32'h0001_0040};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0055, 32'habcd_ef12, 1'b1, 1'b1, 32'habcd_ef00};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hffff_ffff, 32'h0000_0000, 1'b0, 1'b0, 32'hffff_ffe0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_001f, 1'b1, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0021, 32'h0000_0300, 1'b0, 1'b0, 32'h8000_0020};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h7777_7777, 1'b1, 1'b0, 32'h7777_7760};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080};
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst_first) do_reset();
      clear_mon();
      bus.icache_address = vecs[v].ia;
      bus.dcache_address = vecs[v].da;
      bus.dcache_wdata   = {8{$urandom}};
      bus.icache_read    = vecs[v].i_rd;
      bus.dcache_read    = vecs[v].d_rd;
      bus.dcache_write   = vecs[v].d_wr;
      wait_resps($sformatf("vec%0d_done", v), 1, 40);
      drop_all();
      chk($sformatf("vec%0d_winner", v), 256'(served[0]), 256'(vecs[v].exp_d));
      chk($sformatf("vec%0d_addr", v), 256'(burst_addr[0]), 256'(vecs[v].exp_addr));
      chk($sformatf("vec%0d_wr_beats", v), 256'(wr_beats.size()),
          256'(vecs[v].exp_wr ? 4 : 0));
      repeat (2) step();
    end

    // Randomized trials against a round-robin reference model.
    begin
      bit          model_last_d;
      bit          ir;
      int          dop;
      bit          exp_order [$];
      logic [31:0] ia, da;
      logic [255:0] wd;
      do_reset();
      model_last_d = 1'b0;
      for (int t = 0; t < 40; t++) begin
        clear_mon();
        ir  = 1'($urandom_range(0, 1));
        dop = int'($urandom_range(0, 3));
        if (!ir && dop == 0) ir = 1'b1;
        ia = $urandom;
        da = $urandom;
        wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        salt = $urandom;
        for (int g = 0; g < 4; g++) gaps[g] = int'($urandom_range(0, 2));
        wr_gap  = int'($urandom_range(0, 3));
        junk_en = 1'($urandom_range(0, 1));
        exp_order.delete();
        if (ir && dop != 0) begin
          exp_order.push_back(!model_last_d);
          exp_order.push_back(model_last_d);
        end else begin
          exp_order.push_back(dop != 0);
        end
        bus.icache_address = ia;
        bus.dcache_address = da;
        bus.dcache_wdata   = wd;
        bus.icache_read    = ir;
        bus.dcache_read    = (dop == 1) || (dop == 3);
        bus.dcache_write   = (dop >= 2);
        wait_resps($sformatf("rnd%0d_done", t), exp_order.size(), 200);
        drop_all();
        for (int k = 0; k < exp_order.size(); k++) begin
          chk($sformatf("rnd%0d_order%0d", t, k), 256'(served[k]), 256'(exp_order[k]));
          chk($sformatf("rnd%0d_addr%0d", t, k), 256'(burst_addr[k]),
              256'((exp_order[k] ? da : ia) & 32'hffff_ffe0));
          if (!exp_order[k]) chk($sformatf("rnd%0d_iline", t), i_line, exp_line(ia, salt));
          else if (dop == 1) chk($sformatf("rnd%0d_dline", t), d_line, exp_line(da, salt));
        end
        if (dop >= 2) begin
          chk($sformatf("rnd%0d_wr_count", t), 256'(wr_beats.size()), 256'(4));
          for (int b = 0; b < 4 && b < wr_beats.size(); b++)
            chk($sformatf("rnd%0d_wr_beat%0d", t, b), 256'(wr_beats[b]), 256'(wd[b*64 +: 64]));
        end
        model_last_d = exp_order[exp_order.size() - 1];
        repeat (2) step();
      end
      junk_en = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
